// File: rtl/cache_refill_arbiter.sv
// -----------------------------------------------------------------------------
// cache_refill_arbiter
//
// Arbitrates NUM_CH cache refill channels (0 = icache, 1 = dcache, ...) onto a
// single burst read port toward the memory bridge. Only one burst is in flight
// at a time. A cached request fetches a whole LINE_WIDTH line as BEATS beats
// and assembles it. An uncached request fetches a single beat, which lands in
// slot 0 of the returned line with all other slots zero.
//
// Handshakes: a transfer on the AR channel happens on a rising clk edge where
// mem_ar_valid && mem_ar_ready. A transfer on the R channel happens on a
// rising clk edge where mem_r_valid && mem_r_ready. While mem_ar_valid is high
// and no transfer has happened, mem_ar_addr and mem_ar_len do not change.
// Requesters hold ch_rd_req high until their one-cycle ch_ret_valid pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ch_rd_req       per-channel refill request (level)
//   ch_rd_addr      per-channel address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ch_uncache      per-channel single-beat uncached mode, sampled at grant
//   ch_ret_valid    one-cycle completion pulse to the served channel
//   ch_ret_data     returned line, shared; holds until the next completion
//   mem_ar_*        burst address channel (valid/ready/addr/len = beats-1)
//   mem_r_*         read data channel (valid/ready/data/last)
//   busy            FSM is not idle
//   proto_err       sticky: mem_r_last disagreed with the expected beat count
//   dbg_state       current FSM state (IDLE=0, ADDR=1, DATA=2, RESP=3)
// -----------------------------------------------------------------------------
module cache_refill_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_rd_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_rd_addr,
  input  logic [NUM_CH-1:0]            ch_uncache,
  output logic [NUM_CH-1:0]            ch_ret_valid,
  output logic [LINE_WIDTH-1:0]        ch_ret_data,
  output logic                         mem_ar_valid,
  input  logic                         mem_ar_ready,
  output logic [ADDR_WIDTH-1:0]        mem_ar_addr,
  output logic [7:0]                   mem_ar_len,
  input  logic                         mem_r_valid,
  output logic                         mem_r_ready,
  input  logic [BEAT_WIDTH-1:0]        mem_r_data,
  input  logic                         mem_r_last,
  output logic                         busy,
  output logic                         proto_err,
  output logic [1:0]                   dbg_state
);

  localparam int BEATS    = LINE_WIDTH / BEAT_WIDTH;
  localparam int LINE_OFF = $clog2(LINE_WIDTH / 8);
  localparam int BEAT_OFF = $clog2(BEAT_WIDTH / 8);
  localparam int PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [7:0]            FULL_LEN  = 8'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFF;
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = {ADDR_WIDTH{1'b1}} << BEAT_OFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    unc_q, unc_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [LINE_WIDTH-1:0]   ret_q, ret_d;
  logic                    perr_q, perr_d;

  logic [NUM_CH-1:0]       req_rot;
  logic [PTR_W-1:0]        pick;
  logic                    pick_valid;
  logic [7:0]              len_w;
  logic [ADDR_WIDTH-1:0]   ar_addr_w;
  logic                    final_beat;

  // Burst shape follows the uncache bit latched at grant.
  assign len_w      = unc_q ? 8'd0 : FULL_LEN;
  assign ar_addr_w  = unc_q ? (addr_q & BEAT_MASK) : (addr_q & LINE_MASK);
  assign final_beat = (cnt_q == len_w);

  // ---------------------------------------------------------------------------
  // Round-robin pick. The request vector is rotated so that bit 0 is the
  // channel at the RR pointer; the lowest set bit of the rotated vector is the
  // winner, and its absolute index is pointer + offset (mod NUM_CH).
  // ---------------------------------------------------------------------------
  always_comb begin
    int sum;
    sum        = 0;
    req_rot    = NUM_CH'({ch_rd_req, ch_rd_req} >> rr_ptr_q);
    pick       = '0;
    pick_valid = 1'b0;
    // Walk from the highest offset down so the lowest offset wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum = int'(rr_ptr_q) + k;
        if (sum >= NUM_CH) begin
          sum = sum - NUM_CH;
        end
        pick       = PTR_W'(sum);
        pick_valid = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    unc_d    = unc_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    ret_d    = ret_q;
    perr_d   = perr_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          for (int i = 0; i < NUM_CH; i++) begin
            if (pick == PTR_W'(i)) begin
              addr_d = ch_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              unc_d  = ch_uncache[i];
            end
          end
          // Cleared so unused slots of an uncached return read as zero.
          line_d  = '0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (mem_ar_ready) begin
          cnt_d   = 8'd0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (mem_r_valid) begin
          for (int s = 0; s < BEATS; s++) begin
            if (cnt_q == 8'(s)) begin
              line_d[s*BEAT_WIDTH +: BEAT_WIDTH] = mem_r_data;
            end
          end
          // The beat count alone ends the transfer; mem_r_last is only
          // cross-checked against it.
          if (mem_r_last != final_beat) begin
            perr_d = 1'b1;
          end
          if (final_beat) begin
            ret_d   = line_d;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_RESP: begin
        if (grant_q == PTR_W'(NUM_CH - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_q + PTR_W'(1);
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      unc_q    <= 1'b0;
      cnt_q    <= 8'd0;
      line_q   <= '0;
      ret_q    <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      unc_q    <= unc_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      ret_q    <= ret_d;
      perr_q   <= perr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so no request input reaches
  // the memory port combinationally. AR fields are forced to zero outside ADDR.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_ar_valid = (state_q == S_ADDR);
    mem_ar_addr  = (state_q == S_ADDR) ? ar_addr_w : '0;
    mem_ar_len   = (state_q == S_ADDR) ? len_w : 8'd0;
    mem_r_ready  = (state_q == S_DATA);
    busy         = (state_q != S_IDLE);
    proto_err    = perr_q;
    ch_ret_data  = ret_q;
    dbg_state    = state_q;
    ch_ret_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_q == S_RESP) && (grant_q == PTR_W'(i))) begin
        ch_ret_valid[i] = 1'b1;
      end
    end
  end

endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
Parametrised successor to the single-channel icache refill port (rd_req/rd_addr in, ret_valid/ret_data out). It arbitrates NUM_CH cache refill channels (e.g. icache, dcache) onto one burst read port toward the memory bridge. It assembles a LINE_WIDTH cache line from BEAT_WIDTH beats, and it supports a per-channel uncached single-beat mode. It sits between the caches and the AXI bridge.

Parameters:
NUM_CH, 2, number of requesting channels (>=1); index 0 = icache, 1 = dcache.
ADDR_WIDTH, 32, address width.
LINE_WIDTH, 256, cache line bits returned per refill.
BEAT_WIDTH, 32, memory data beat width; LINE_WIDTH is an integer multiple of it. BEATS = LINE_WIDTH/BEAT_WIDTH (derived, <=256).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_rd_req  in  NUM_CH  per-channel request, level held until that channel's ret_valid
ch_rd_addr  in  NUM_CH*ADDR_WIDTH  per-channel address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
ch_uncache  in  NUM_CH  per-channel single-beat uncached mode, sampled with the request
ch_ret_valid  out  NUM_CH  one-cycle pulse to the served channel
ch_ret_data  out  LINE_WIDTH  returned line, shared by all channels, valid with ch_ret_valid
mem_ar_valid  out  1  burst address valid
mem_ar_ready  in  1  burst address accepted
mem_ar_addr  out  ADDR_WIDTH  burst start address
mem_ar_len  out  8  beats-1
mem_r_valid  in  1  read beat valid
mem_r_ready  out  1  read beat accept
mem_r_data  in  BEAT_WIDTH  read beat
mem_r_last  in  1  last beat marker
busy  out  1  FSM not IDLE
proto_err  out  1  sticky: mem_r_last mismatched beat count

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, RR pointer=0, beat counter=0, line buffer=0. All outputs 0, including proto_err.
- FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE: if any ch_rd_req is high, grant round-robin starting at the RR pointer. Latch grant index, address and uncache bit. Go to ADDR next cycle. No combinational path from ch_rd_req to mem_ar_valid.
- ADDR: mem_ar_valid=1; addr/len are stable while valid and not ready.
  - Cached: addr = latched addr with low log2(LINE_WIDTH/8) bits cleared; len = BEATS-1.
  - Uncached: addr = latched addr with low log2(BEAT_WIDTH/8) bits cleared; len = 0.
  - On mem_ar_valid & mem_ar_ready: go to DATA, beat counter=0.
- DATA: mem_r_ready=1. Each mem_r_valid cycle writes mem_r_data into line[cnt*BEAT_WIDTH +: BEAT_WIDTH] and increments cnt.
  - In uncached mode the beat goes to slot 0 and the other slots read as 0.
  - Transfer ends on the expected final beat (cnt==len), then go to RESP.
  - If mem_r_last disagrees with the final-beat condition (early or missing), set proto_err. The transfer still ends on the beat count; any stray later beats are accepted only while in DATA.
- RESP (one cycle): ch_ret_valid[grant]=1, ch_ret_data = assembled line. RR pointer = grant+1 (mod NUM_CH). Go to IDLE.
- Min latency, req to ret_valid: 1 (IDLE) + 1 (ADDR, ready=1) + BEATS + 1 (RESP). With defaults and no stalls this is 11 cycles; uncached is 4.
- ch_ret_data holds its value after RESP until the next RESP. Only the granted channel sees ret_valid.
- Requester drops ch_rd_req mid-transaction: the transaction completes and ret_valid still pulses. The requester ignores it.
- Requester changes address mid-transaction: ignored, because the address was latched at grant.
- Multiple requests: at most one outstanding burst. The RR pointer guarantees each channel is served within NUM_CH transactions.
- Re-request in the cycle after its own ret_valid: treated as a new request.
- rst in the middle of a burst: immediate return to the reset state. Memory side must be reset together (integration rule); no drain.
- NUM_CH=1: grant is always 0 and the RR pointer is a constant.

Test Plan:
1. Single cached refill: ch0 req addr=0x1C000024, ar_ready=1, 8 beats 0x0..0x7 with last on beat 7 -> ar_addr=0x1C000020, len=7. ret_valid[0] pulses at cycle 11 and ch_ret_data[31:0]=0, [255:224]=7.
2. Uncached: ch1 req addr=0xBFAF8004, uncache=1, beat 0xDEADBEEF -> ar_addr=0xBFAF8004, len=0, ch_ret_data=0x...0DEADBEEF with upper bits 0, ret_valid[1] only.
3. Round-robin: ch0 and ch1 request together and ch0 re-requests immediately -> serviced order ch0, ch1, ch0; never ch0 twice in a row.
4. Backpressure: ar_ready low 5 cycles, r_valid gaps between beats -> ar_addr/len stable while waiting, line is correct, latency grows by exactly the stall cycles.
5. Protocol error: r_last asserted on beat 3 of 8 -> proto_err=1 stays set, transfer still completes after 8 beats; rst clears proto_err.
6. Reset during DATA after beat 4 -> next cycle busy=0, all ret_valid=0; a fresh request then completes normally.
